// File: rtl/arr_access_sched_pkg.sv
// Shared types and helpers for the round-robin 3-D table scheduler.
// ARR_SCHED_RMW_EN adds the read-modify-write WB state.
package arr_sched_pkg;

  localparam int unsigned NREQ_DEF   = 4;
  localparam int unsigned WIDTH_DEF  = 16;
  localparam int unsigned PLANES_DEF = 3;
  localparam int unsigned ROWS_DEF   = 2;
  localparam int unsigned COLS_DEF   = 4;
  localparam int unsigned IDW_DEF    = $clog2(NREQ_DEF);

`ifdef ARR_SCHED_RMW_EN
  typedef enum logic [1:0] {INIT, RUN, WB} state_e;
`else
  typedef enum logic {INIT, RUN} state_e;
`endif

  // Sized by the package defaults; the top checks its parameters agree.
  typedef struct packed {
    logic                 valid;
    logic [IDW_DEF-1:0]   id;
    logic                 err;
    logic [WIDTH_DEF-1:0] data;
  } rsp_t;

  function automatic int unsigned clog2_min1(input int unsigned n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

  function automatic int unsigned depth_f(input int unsigned planes,
                                          input int unsigned rows,
                                          input int unsigned cols);
    return planes * rows * cols;
  endfunction

  function automatic int unsigned lin_index(input int unsigned p,
                                            input int unsigned r,
                                            input int unsigned c,
                                            input int unsigned rows,
                                            input int unsigned cols);
    return p * rows * cols + r * cols + c;
  endfunction

endpackage

// File: rtl/arr_access_sched_if.sv
// Requester/response bundle for arr_access_sched.
// ARR_SCHED_RMW_EN adds req_add.
interface arr_access_sched_if
  import arr_sched_pkg::*;
#(
  parameter int unsigned NREQ   = NREQ_DEF,
  parameter int unsigned WIDTH  = WIDTH_DEF,
  parameter int unsigned PLANES = PLANES_DEF,
  parameter int unsigned ROWS   = ROWS_DEF,
  parameter int unsigned COLS   = COLS_DEF
) ();
  localparam int unsigned PW  = clog2_min1(PLANES);
  localparam int unsigned RW  = clog2_min1(ROWS);
  localparam int unsigned CW  = clog2_min1(COLS);
  localparam int unsigned IDW = clog2_min1(NREQ);

  logic [NREQ-1:0]            req_valid;
  logic [NREQ-1:0]            req_ready;
  logic [NREQ-1:0]            req_we;
`ifdef ARR_SCHED_RMW_EN
  logic [NREQ-1:0]            req_add;
`endif
  logic [NREQ-1:0][PW-1:0]    req_plane;
  logic [NREQ-1:0][RW-1:0]    req_row;
  logic [NREQ-1:0][CW-1:0]    req_col;
  logic [NREQ-1:0][WIDTH-1:0] req_wdata;
  logic                       rsp_valid;
  logic [IDW-1:0]             rsp_id;
  logic [WIDTH-1:0]           rsp_data;
  logic                       rsp_err;
  logic                       busy;

  modport master (
    output req_valid, req_we, req_plane, req_row, req_col, req_wdata,
`ifdef ARR_SCHED_RMW_EN
    output req_add,
`endif
    input  req_ready, rsp_valid, rsp_id, rsp_data, rsp_err, busy
  );

  modport slave (
    input  req_valid, req_we, req_plane, req_row, req_col, req_wdata,
`ifdef ARR_SCHED_RMW_EN
    input  req_add,
`endif
    output req_ready, rsp_valid, rsp_id, rsp_data, rsp_err, busy
  );
endinterface

// File: rtl/arr_access_sched_rr_arbiter.sv
// Combinational round-robin arbiter: first request at or after ptr_i, circularly.
module rr_arbiter
  import arr_sched_pkg::*;
#(
  parameter int unsigned NREQ = NREQ_DEF,
  parameter int unsigned IDW  = clog2_min1(NREQ)
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [IDW-1:0]  ptr_i,
  output logic [NREQ-1:0] gnt_o,
  output logic [IDW-1:0]  idx_o,
  output logic            any_o
);
  int unsigned k;

  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    any_o = 1'b0;
    k     = 0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      k = (32'(ptr_i) + i) % NREQ;
      if (!any_o && req_i[k]) begin
        any_o    = 1'b1;
        gnt_o[k] = 1'b1;
        idx_o    = IDW'(k);
      end
    end
  end
endmodule

// File: rtl/arr_access_sched.sv
// Round-robin scheduler sharing one self-initialising PLANES x ROWS x COLS word table.
// ARR_SCHED_RMW_EN enables read-modify-write add via req_add and a WB state.
module arr_access_sched
  import arr_sched_pkg::*;
#(
  parameter int unsigned NREQ   = NREQ_DEF,
  parameter int unsigned WIDTH  = WIDTH_DEF,
  parameter int unsigned PLANES = PLANES_DEF,
  parameter int unsigned ROWS   = ROWS_DEF,
  parameter int unsigned COLS   = COLS_DEF
) (
  input  logic               clk_i,
  input  logic               rst_i,
  arr_access_sched_if.slave  bus
);
  localparam int unsigned DEPTH = depth_f(PLANES, ROWS, COLS);
  localparam int unsigned AW    = clog2_min1(DEPTH);
  localparam int unsigned IDW   = clog2_min1(NREQ);
  localparam int unsigned PW    = clog2_min1(PLANES);
  localparam int unsigned RW    = clog2_min1(ROWS);
  localparam int unsigned CW    = clog2_min1(COLS);

  if (IDW != IDW_DEF || WIDTH != WIDTH_DEF) begin : g_cfg_chk
    $error("arr_access_sched: NREQ/WIDTH must match arr_sched_pkg rsp_t sizing");
  end

  logic [WIDTH-1:0] mem_q [DEPTH];

  state_e         state_q;
  logic [AW-1:0]  init_cnt_q;
  logic [IDW-1:0] rr_q;
  rsp_t           rsp_q, rsp_d;
  logic           busy_q;

  logic [NREQ-1:0]  req_run, gnt;
  logic [IDW-1:0]   gidx, rr_nxt;
  logic             accept;
  logic             sel_we;
  logic [PW-1:0]    sel_p;
  logic [RW-1:0]    sel_r;
  logic [CW-1:0]    sel_c;
  logic [WIDTH-1:0] sel_wd, rd_data;
  logic             oob, wr_plain;
  logic [AW-1:0]    addr;

  assign req_run = (state_q == RUN) ? bus.req_valid : '0;

  rr_arbiter #(.NREQ(NREQ), .IDW(IDW)) u_arb (
    .req_i (req_run),
    .ptr_i (rr_q),
    .gnt_o (gnt),
    .idx_o (gidx),
    .any_o (accept)
  );

  assign sel_we  = bus.req_we[gidx];
  assign sel_p   = bus.req_plane[gidx];
  assign sel_r   = bus.req_row[gidx];
  assign sel_c   = bus.req_col[gidx];
  assign sel_wd  = bus.req_wdata[gidx];
  assign oob     = (32'(sel_p) >= PLANES) || (32'(sel_r) >= ROWS) || (32'(sel_c) >= COLS);
  assign addr    = AW'(lin_index(32'(sel_p), 32'(sel_r), 32'(sel_c), ROWS, COLS));
  assign rd_data = oob ? '0 : mem_q[addr];
  assign rr_nxt  = (32'(gidx) == NREQ - 1) ? '0 : gidx + 1'b1;

`ifdef ARR_SCHED_RMW_EN
  logic             sel_add;
  logic [AW-1:0]    wb_addr_q;
  logic [WIDTH-1:0] wb_sum_q;
  assign sel_add  = bus.req_add[gidx];
  assign wr_plain = accept && sel_we && !oob && !sel_add;
`else
  assign wr_plain = accept && sel_we && !oob;
`endif

  always_comb begin
    rsp_d = '0;
    if (accept) begin
      rsp_d.valid = 1'b1;
      rsp_d.id    = gidx;
      rsp_d.err   = oob;
      rsp_d.data  = rd_data;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= INIT;
      init_cnt_q <= '0;
      rr_q       <= '0;
      rsp_q      <= '0;
      busy_q     <= 1'b1;
`ifdef ARR_SCHED_RMW_EN
      wb_addr_q  <= '0;
      wb_sum_q   <= '0;
`endif
    end else begin
      rsp_q <= rsp_d;
      case (state_q)
        INIT: begin
          init_cnt_q <= init_cnt_q + 1'b1;
          if (32'(init_cnt_q) == DEPTH - 1) begin
            init_cnt_q <= '0;
            state_q    <= RUN;
            busy_q     <= 1'b0;
          end
        end
        RUN: begin
          if (accept) begin
            rr_q <= rr_nxt;
`ifdef ARR_SCHED_RMW_EN
            // Response leaves with the old value now; the sum lands one cycle later.
            if (sel_we && sel_add && !oob) begin
              state_q   <= WB;
              wb_addr_q <= addr;
              wb_sum_q  <= rd_data + sel_wd;
            end
`endif
          end
        end
`ifdef ARR_SCHED_RMW_EN
        WB: state_q <= RUN;
`endif
        default: state_q <= INIT;
      endcase
    end
  end

  // Table storage carries no reset; INIT rewrites every word after each reset.
  always_ff @(posedge clk_i) begin
    if (state_q == INIT) begin
      mem_q[init_cnt_q] <= WIDTH'(init_cnt_q);
    end else if (wr_plain) begin
      mem_q[addr] <= sel_wd;
    end
`ifdef ARR_SCHED_RMW_EN
    else if (state_q == WB) begin
      mem_q[wb_addr_q] <= wb_sum_q;
    end
`endif
  end

  assign bus.req_ready = gnt;
  assign bus.rsp_valid = rsp_q.valid;
  assign bus.rsp_id    = rsp_q.id;
  assign bus.rsp_err   = rsp_q.err;
  assign bus.rsp_data  = rsp_q.data;
  assign bus.busy      = busy_q;
endmodule

// File: tb/tb_arr_access_sched.sv
// Directed self-checking bench for arr_access_sched (RMW cases under ARR_SCHED_RMW_EN).
module tb_arr_access_sched;
  localparam int NREQ = 4, WIDTH = 16, PLANES = 3, ROWS = 2, COLS = 4;
  localparam int PW = 2, RW = 1, CW = 2, DEPTH = 24;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  arr_access_sched_if #(.NREQ(NREQ), .WIDTH(WIDTH), .PLANES(PLANES), .ROWS(ROWS), .COLS(COLS)) bus ();

  arr_access_sched #(.NREQ(NREQ), .WIDTH(WIDTH), .PLANES(PLANES), .ROWS(ROWS), .COLS(COLS)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;
  logic [WIDTH-1:0] model [DEPTH];

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_reqs();
    bus.req_valid = '0;
    bus.req_we    = '0;
    bus.req_plane = '0;
    bus.req_row   = '0;
    bus.req_col   = '0;
    bus.req_wdata = '0;
`ifdef ARR_SCHED_RMW_EN
    bus.req_add   = '0;
`endif
  endtask

  task automatic set_req(input int id, input logic we, input int p, input int r, input int c,
                         input logic [WIDTH-1:0] wd);
    bus.req_valid[id] = 1'b1;
    bus.req_we[id]    = we;
    bus.req_plane[id] = PW'(p);
    bus.req_row[id]   = RW'(r);
    bus.req_col[id]   = CW'(c);
    bus.req_wdata[id] = wd;
  endtask

  // One isolated request: grant this cycle, response on the next.
  task automatic single(input string tag, input int id, input logic we, input int p, input int r,
                        input int c, input logic [WIDTH-1:0] wd, input logic [WIDTH-1:0] exp_d,
                        input logic exp_err);
    clear_reqs();
    set_req(id, we, p, r, c, wd);
    #1;
    check({tag, "_ready"}, 32'(bus.req_ready), 32'(1) << id);
    tick();
    check({tag, "_vld"},  32'(bus.rsp_valid), 1);
    check({tag, "_id"},   32'(bus.rsp_id), id);
    check({tag, "_err"},  32'(bus.rsp_err), 32'(exp_err));
    check({tag, "_data"}, 32'(bus.rsp_data), 32'(exp_d));
    clear_reqs();
  endtask

  task automatic wait_init(input string tag);
    int n = 0;
    while (bus.busy && n < 100) begin
      tick();
      n++;
    end
    check(tag, n, DEPTH);
  endtask

  task automatic table_scan(input string tag);
    for (int k = 0; k < DEPTH; k++)
      single($sformatf("%s%0d", tag, k), k % NREQ, 1'b0, k / 8, (k / 4) % 2, k % 4, '0, model[k], 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int k = 0; k < DEPTH; k++) model[k] = WIDTH'(k);
    clear_reqs();
    tick();
    tick();
    check("rst_busy", 32'(bus.busy), 1);
    check("rst_rsp_vld", 32'(bus.rsp_valid), 0);
    bus.req_valid = '1;
    #1;
    check("rst_ready", 32'(bus.req_ready), 0);
    clear_reqs();
    rst = 1'b0;
    wait_init("init_len");

    single("rd212", 0, 1'b0, 2, 1, 2, '0, 16'd22, 1'b0);
    single("rd000", 0, 1'b0, 0, 0, 0, '0, 16'd0, 1'b0);

    single("wr101", 0, 1'b1, 1, 0, 1, 16'hABCD, 16'd9, 1'b0);
    model[9] = 16'hABCD;
    single("rb101", 0, 1'b0, 1, 0, 1, '0, 16'hABCD, 1'b0);
    single("rd013", 3, 1'b0, 0, 1, 3, '0, 16'd7, 1'b0);

    // All four requesters hold reads of (0,0,i); pointer sits at 0 here.
    clear_reqs();
    for (int i = 0; i < NREQ; i++) set_req(i, 1'b0, 0, 0, i, '0);
    for (int s = 0; s < 5; s++) begin
      #1;
      check($sformatf("rr_gnt%0d", s), 32'(bus.req_ready), 32'(1) << (s % 4));
      tick();
      check($sformatf("rr_vld%0d", s), 32'(bus.rsp_valid), 1);
      check($sformatf("rr_id%0d", s), 32'(bus.rsp_id), s % 4);
      check($sformatf("rr_data%0d", s), 32'(bus.rsp_data), s % 4);
    end
    clear_reqs();

    single("oob_rd", 1, 1'b0, 3, 0, 0, '0, '0, 1'b1);
    single("oob_wr", 1, 1'b1, 3, 1, 0, 16'hBEEF, '0, 1'b1);
    table_scan("tbl");

`ifdef ARR_SCHED_RMW_EN
    clear_reqs();
    set_req(0, 1'b1, 0, 0, 1, 16'hFFFF);
    bus.req_add[0] = 1'b1;
    #1;
    check("rmw_ready", 32'(bus.req_ready), 1);
    tick();
    check("rmw_vld", 32'(bus.rsp_valid), 1);
    check("rmw_data", 32'(bus.rsp_data), 1);
    clear_reqs();
    set_req(2, 1'b0, 0, 0, 1, '0);
    #1;
    check("rmw_wb_ready", 32'(bus.req_ready), 0);
    tick();
    check("rmw_wb_vld", 32'(bus.rsp_valid), 0);
    #1;
    check("rmw_rd_ready", 32'(bus.req_ready), 4);
    tick();
    check("rmw_rd_id", 32'(bus.rsp_id), 2);
    check("rmw_rd_data", 32'(bus.rsp_data), 0);
    clear_reqs();
`endif

    // Reset with an accepted-but-unanswered read in flight.
    clear_reqs();
    set_req(1, 1'b0, 2, 0, 0, '0);
    #1;
    check("pend_ready", 32'(bus.req_ready), 2);
    rst = 1'b1;
    tick();
    check("pend_rsp_vld", 32'(bus.rsp_valid), 0);
    check("pend_busy", 32'(bus.busy), 1);
    clear_reqs();
    tick();
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (i == 5) begin
        bus.req_valid = '1;
        #1;
        check("init_ready", 32'(bus.req_ready), 0);
        clear_reqs();
      end
      tick();
    end
    check("mid_init_busy", 32'(bus.busy), 1);
    rst = 1'b1;
    #1;
    check("mid_rst_busy", 32'(bus.busy), 1);
    tick();
    rst = 1'b0;
    wait_init("reinit_len");
    for (int k = 0; k < DEPTH; k++) model[k] = WIDTH'(k);
    table_scan("reidx");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
